// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a byte stream (count header followed by
// little-endian words) into consecutive imem writes while holding the core stalled.
module imem_loader #(
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    word_count;
    logic [7:0]    word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_low;
    logic [TW-1:0] idle_count;

    logic          accept;
    logic          bad_count;
    logic          timed_out;
    logic          last_word;

    // Only HDR and DATA listen to the byte source; WRITE is the one-cycle bubble per word.
    assign in_ready = (state == HDR) || (state == DATA);
    assign mem_rw   = (state != WRITE);

    always_comb begin
        accept     = in_valid && in_ready;
        bad_count  = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));
        timed_out  = (idle_count == TW'(TIMEOUT - 1)) && !accept;
        last_word  = ({1'b0, word_idx} + 9'd1) == {1'b0, word_count};
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    state_next = bad_count ? IDLE : DATA;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = last_word ? FIN : DATA;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and pulse outputs; the word's final byte goes straight into mem_wdata so the
    // write port is presented together with the WRITE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= 8'd0;
            word_idx   <= 8'd0;
            byte_idx   <= 2'd0;
            word_low   <= 24'd0;
            idle_count <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cpu_hold   <= 1'b1;
                        idle_count <= '0;
                        word_idx   <= 8'd0;
                        byte_idx   <= 2'd0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        idle_count <= '0;
                        if (bad_count) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            word_count <= in_data;
                            word_idx   <= 8'd0;
                            byte_idx   <= 2'd0;
                        end
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        idle_count <= idle_count + 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        idle_count <= '0;
                        byte_idx   <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_low[7:0]   <= in_data;
                            2'd1: word_low[15:8]  <= in_data;
                            2'd2: word_low[23:16] <= in_data;
                            default: begin
                                mem_wdata <= {in_data, word_low};
                                mem_addr  <= 32'(BASE_ADDR) + {24'd0, word_idx};
                            end
                        endcase
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        idle_count <= idle_count + 1'b1;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 8'd1;
                    byte_idx <= 2'd0;
                    if (last_word) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: a byte-stream model predicts writes and end events,
// and a negedge monitor checks them as the loader presents them.
module tb_imem_loader;

    localparam int DEPTH     = 32;
    localparam int BASE_ADDR = 0;
    localparam int TIMEOUT   = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [63:0] expWrites[$];
    int          expEvents[$];
    logic [7:0]  stim[$];

    imem_loader #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE_ADDR),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rw(mem_rw),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the loader writes or ends a load.
    always @(negedge clk) begin
        logic [63:0] e;
        int ev;
        if (reset === 1'b0) begin
            if (mem_rw === 1'b0) begin
                checkOutput("in_ready_in_write", {31'd0, in_ready}, 32'd0);
                if (expWrites.size() == 0) begin
                    checkOutput("unexpected_write", {31'd0, mem_rw}, 32'd1);
                end else begin
                    e = expWrites.pop_front();
                    checkOutput("write_addr", mem_addr, e[63:32]);
                    checkOutput("write_data", mem_wdata, e[31:0]);
                end
            end
            if (done === 1'b1 || err === 1'b1) begin
                checkOutput("hold_at_end", {31'd0, cpu_hold}, 32'd0);
                if (expEvents.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, done, err}, 32'd0);
                end else begin
                    ev = expEvents.pop_front();
                    checkOutput(ev == 1 ? "err_pulse" : "done_pulse", {30'd0, done, err},
                                ev == 1 ? 32'd1 : 32'd2);
                    checkOutput("writes_before_end", expWrites.size(), 32'd0);
                end
            end
        end
    end

    // Caller sits at a negedge; returns at the negedge following the accepting edge.
    task automatic sendByte(input logic [7:0] b, input int stallPct);
        int guard;
        guard = 0;
        while ($urandom_range(99) < stallPct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_mem_rw"}, {31'd0, mem_rw}, 32'd1);
        checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        checkOutput({tag, "_done_err"}, {30'd0, done, err}, 32'd0);
    endtask

    // Runs one load from stim[]: header byte first, then as many bytes as are present.
    task automatic applyStimulus(input int stallPct, input bit pokeStart);
        int n;
        int nsend;
        int nwords;
        int c;
        bit badHdr;
        bit complete;
        logic [31:0] w;
        n      = int'(stim[0]);
        badHdr = (n == 0) || (n > DEPTH);
        nsend  = badHdr ? 1 : ((stim.size() < 1 + 4 * n) ? stim.size() : 1 + 4 * n);
        complete = !badHdr && (nsend == 1 + 4 * n);
        nwords = badHdr ? 0 : (nsend - 1) / 4;
        for (int k = 0; k < nwords; k++) begin
            w = 32'(stim[1 + 4 * k]) + (32'(stim[2 + 4 * k]) << 8) +
                (32'(stim[3 + 4 * k]) << 16) + (32'(stim[4 + 4 * k]) << 24);
            expWrites.push_back({32'(BASE_ADDR + k), w});
        end
        expEvents.push_back(complete ? 0 : 1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < nsend; i++) begin
            sendByte(stim[i], stallPct);
            if (pokeStart && i == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (badHdr) begin
            checkOutput("bad_hdr_err_latency", {31'd0, err}, 32'd1);
        end
        c = 0;
        while (expEvents.size() != 0 && c < TIMEOUT + 50) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        checkOutput("load_end_seen", expEvents.size(), 32'd0);
        checkOutput("hold_after_end", {31'd0, cpu_hold}, 32'd0);
        if (!badHdr && !complete) begin
            checkOutput("timeout_window", {31'd0, (c >= TIMEOUT - 1) && (c <= TIMEOUT + 3)}, 32'd1);
        end
    endtask

    task automatic randomLoad(input int n, input int stallPct);
        stim.delete();
        stim.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            stim.push_back(8'($urandom_range(255)));
        end
        applyStimulus(stallPct, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (4) begin
            @(negedge clk);
            checkOutput("idle_not_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        stim = '{8'h05, 8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00, 8'h33, 8'h81,
                 8'h20, 8'h00, 8'hb3, 8'h80, 8'h20, 8'h00, 8'hef, 8'hf1, 8'hdf, 8'hff};
        applyStimulus(0, 1'b0);

        stim = '{8'h00};
        applyStimulus(0, 1'b0);
        stim = '{8'h33};
        applyStimulus(0, 1'b0);
        stim = '{8'h21};
        applyStimulus(0, 1'b0);

        stim = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(0, 1'b0);

        randomLoad(2, 45);
        stim.push_back(8'h00);
        stim[0] = 8'h02;
        applyStimulus(0, 1'b1);
        randomLoad(DEPTH, 0);
        for (int r = 0; r < 5; r++) begin
            randomLoad($urandom_range(1, 8), $urandom_range(0, 50));
        end

        // Reset in the middle of word 1: word 0 is written, nothing else is expected.
        stim.delete();
        stim.push_back(8'h03);
        for (int i = 0; i < 12; i++) begin
            stim.push_back(8'($urandom_range(255)));
        end
        expWrites.push_back({32'(BASE_ADDR), {stim[4], stim[3], stim[2], stim[1]}});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sendByte(stim[i], 0);
        end
        checkOutput("word0_written_before_reset", expWrites.size(), 32'd0);
        reset = 1'b1;
        #1;
        checkResetOutputs("midload_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        randomLoad(3, 20);

        checkOutput("writes_left", expWrites.size(), 32'd0);
        checkOutput("events_left", expEvents.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
